controle_ataque: RTL and testbench

- Sequences the ATAQUE phase of the naval battle game: takes a target coordinate from the switches, waits for a confirm press, checks the shot against the map, and records it.
- Keeps a shot mask, a hit mask, an attempt counter and a hit counter.
- Declares end of game on victory or when the attempt limit is reached.
- Sits between the status decoder (ATAQUE), the map selector (mapa0..mapa4) and the LED-matrix/display drivers, which render its masks and counters.

---
 rtl/controle_ataque.sv | 192 +++++++++++++++++++
 tb/tb_controle_ataque.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/controle_ataque.sv
// controle_ataque
// Runs the ATAQUE phase of the naval battle game. The ship map is latched
// when the phase starts. Each confirm press takes the switch coordinate,
// checks it against the map and records it in the shot and hit masks.
// The game ends on victory or when the attempt limit is reached.
//
// Ports
//   clock, reset_n          : clock, synchronous active-low reset
//   enable                  : high while the game is in ATAQUE
//   linha, coluna           : target row (0..6) and column (0..4)
//   confirmar               : confirm button (debounced, active-high)
//   mapa0..mapa4            : ship map, mapaK[r] = ship at column K, row r
//   tiro0..tiro4            : shots fired (same bit mapping as the map)
//   acerto0..acerto4        : hits scored (same bit mapping as the map)
//   tentativas, acertos     : valid shot count and hit count
//   resultado               : 00 none, 01 miss, 10 hit, 11 repeated/invalid
//   novo_resultado          : one-cycle pulse when resultado is updated
//   fim, vitoria            : game over, and whether it was a victory
module controle_ataque #(
   parameter int MAX_TENTATIVAS = 20,
   parameter int CONT_W         = 6
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              enable,
   input  logic [2:0]        linha,
   input  logic [2:0]        coluna,
   input  logic              confirmar,
   input  logic [6:0]        mapa0,
   input  logic [6:0]        mapa1,
   input  logic [6:0]        mapa2,
   input  logic [6:0]        mapa3,
   input  logic [6:0]        mapa4,
   output logic [6:0]        tiro0,
   output logic [6:0]        tiro1,
   output logic [6:0]        tiro2,
   output logic [6:0]        tiro3,
   output logic [6:0]        tiro4,
   output logic [6:0]        acerto0,
   output logic [6:0]        acerto1,
   output logic [6:0]        acerto2,
   output logic [6:0]        acerto3,
   output logic [6:0]        acerto4,
   output logic [CONT_W-1:0] tentativas,
   output logic [CONT_W-1:0] acertos,
   output logic [1:0]        resultado,
   output logic              novo_resultado,
   output logic              fim,
   output logic              vitoria
);

   typedef enum logic [1:0] {OCIOSO, ESPERA, VALIDA, FIM} estado_t;

   estado_t           estado_q;
   logic              conf_prev_q;
   logic [34:0]       mapa_q, tiro_q, acerto_q;
   logic [5:0]        total_q;
   logic [2:0]        linha_q, coluna_q;
   logic [CONT_W-1:0] tent_q, acer_q;
   logic [1:0]        res_q;
   logic              novo_q, fim_q, vit_q;

   // Flattened map/mask view: bit index = coluna*7 + linha.
   logic [34:0]       mapa_in;
   logic [5:0]        total_d;
   logic              fora_d, repetido_d, navio_d, press_d;
   logic [5:0]        idx_d;
   logic [34:0]       sel_d, tiro_d, acerto_d;
   logic [CONT_W-1:0] tent_d, acer_d;
   logic [1:0]        res_d;

   assign mapa_in = {mapa4, mapa3, mapa2, mapa1, mapa0};
   assign press_d = confirmar & ~conf_prev_q;

   always_comb begin
      total_d = '0;
      for (int i = 0; i < 35; i++) begin
         total_d = total_d + 6'(mapa_in[i]);
      end

      fora_d     = (linha_q > 3'd6) || (coluna_q > 3'd4);
      idx_d      = 6'(coluna_q) * 6'd7 + 6'(linha_q);
      // Out-of-range coordinates may still alias a legal bit, so every use
      // of sel_d below is gated by fora_d.
      sel_d      = 35'(1) << idx_d;
      repetido_d = |(tiro_q & sel_d);
      navio_d    = |(mapa_q & sel_d);

      tiro_d   = tiro_q;
      acerto_d = acerto_q;
      tent_d   = tent_q;
      acer_d   = acer_q;
      res_d    = 2'b11;
      if (!fora_d && !repetido_d) begin
         tiro_d = tiro_q | sel_d;
         tent_d = tent_q + 1'b1;
         if (navio_d) begin
            acerto_d = acerto_q | sel_d;
            acer_d   = acer_q + 1'b1;
            res_d    = 2'b10;
         end else begin
            res_d    = 2'b01;
         end
      end
   end

   always_ff @(posedge clock) begin
      // The edge detector keeps tracking the button in every state so that a
      // button held across a state change never looks like a fresh press.
      conf_prev_q <= reset_n ? confirmar : 1'b0;
      novo_q      <= 1'b0;

      if (!reset_n || !enable) begin
         estado_q <= OCIOSO;
         tiro_q   <= '0;
         acerto_q <= '0;
         tent_q   <= '0;
         acer_q   <= '0;
         res_q    <= 2'b00;
         fim_q    <= 1'b0;
         vit_q    <= 1'b0;
         if (!reset_n) begin
            mapa_q   <= '0;
            total_q  <= '0;
            linha_q  <= '0;
            coluna_q <= '0;
         end
      end else begin
         case (estado_q)
            OCIOSO: begin
               mapa_q  <= mapa_in;
               total_q <= total_d;
               if (total_d == 6'd0) begin
                  estado_q <= FIM;
                  fim_q    <= 1'b1;
                  vit_q    <= 1'b0;
               end else begin
                  estado_q <= ESPERA;
               end
            end
            ESPERA: begin
               if (press_d) begin
                  linha_q  <= linha;
                  coluna_q <= coluna;
                  estado_q <= VALIDA;
               end
            end
            VALIDA: begin
               tiro_q   <= tiro_d;
               acerto_q <= acerto_d;
               tent_q   <= tent_d;
               acer_q   <= acer_d;
               res_q    <= res_d;
               novo_q   <= 1'b1;
               // Victory is checked first so a fleet-completing last shot wins.
               if (acer_d == CONT_W'(total_q)) begin
                  estado_q <= FIM;
                  fim_q    <= 1'b1;
                  vit_q    <= 1'b1;
               end else if (tent_d == CONT_W'(MAX_TENTATIVAS)) begin
                  estado_q <= FIM;
                  fim_q    <= 1'b1;
                  vit_q    <= 1'b0;
               end else begin
                  estado_q <= ESPERA;
               end
            end
            default: begin
               estado_q <= FIM;
            end
         endcase
      end
   end

   assign tiro0          = tiro_q[6:0];
   assign tiro1          = tiro_q[13:7];
   assign tiro2          = tiro_q[20:14];
   assign tiro3          = tiro_q[27:21];
   assign tiro4          = tiro_q[34:28];
   assign acerto0        = acerto_q[6:0];
   assign acerto1        = acerto_q[13:7];
   assign acerto2        = acerto_q[20:14];
   assign acerto3        = acerto_q[27:21];
   assign acerto4        = acerto_q[34:28];
   assign tentativas     = tent_q;
   assign acertos        = acer_q;
   assign resultado      = res_q;
   assign novo_resultado = novo_q;
   assign fim            = fim_q;
   assign vitoria        = vit_q;

endmodule

// File: tb/tb_controle_ataque.sv
// Testbench for controle_ataque: a reference model pushes the expected
// outcome of every shot into a scoreboard, and a monitor pops and compares
// on each novo_resultado pulse. State is also checked directly after
// resets, aborts and ignored presses.
module tb_controle_ataque;

   localparam int MAXT = 4;

   logic       clock = 1'b0;
   logic       reset_n, enable, confirmar;
   logic [2:0] linha, coluna;
   logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;
   logic [6:0] tiro0, tiro1, tiro2, tiro3, tiro4;
   logic [6:0] acerto0, acerto1, acerto2, acerto3, acerto4;
   logic [5:0] tentativas, acertos;
   logic [1:0] resultado;
   logic       novo_resultado, fim, vitoria;

   controle_ataque #(.MAX_TENTATIVAS(MAXT), .CONT_W(6)) dut (
      .clock(clock), .reset_n(reset_n), .enable(enable),
      .linha(linha), .coluna(coluna), .confirmar(confirmar),
      .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
      .tiro0(tiro0), .tiro1(tiro1), .tiro2(tiro2), .tiro3(tiro3), .tiro4(tiro4),
      .acerto0(acerto0), .acerto1(acerto1), .acerto2(acerto2),
      .acerto3(acerto3), .acerto4(acerto4),
      .tentativas(tentativas), .acertos(acertos), .resultado(resultado),
      .novo_resultado(novo_resultado), .fim(fim), .vitoria(vitoria)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0]  res;
      logic [34:0] tiro;
      logic [34:0] acerto;
      int          tent;
      int          acer;
      logic        fim;
      logic        vit;
   } exp_t;

   exp_t        sb[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          pulse_cnt = 0;
   int          pulse_cyc = 0;

   // Reference model of the game
   logic [34:0] m_map, m_tiro, m_acerto;
   int          m_tent, m_acer, m_total;
   logic [1:0]  m_res;
   logic        m_fim, m_vit;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Scoreboard monitor
   always @(negedge clock) begin
      if (novo_resultado === 1'b1) begin
         exp_t e;
         pulse_cnt++;
         pulse_cyc = cyc;
         if (sb.size() == 0) begin
            check("unexpected_pulse", 64'(novo_resultado), 64'd0);
         end else begin
            e = sb.pop_front();
            check("resultado", 64'(resultado), 64'(e.res));
            check("tiro", 64'({tiro4, tiro3, tiro2, tiro1, tiro0}), 64'(e.tiro));
            check("acerto", 64'({acerto4, acerto3, acerto2, acerto1, acerto0}), 64'(e.acerto));
            check("tentativas", 64'(tentativas), 64'(e.tent));
            check("acertos", 64'(acertos), 64'(e.acer));
            check("fim", 64'(fim), 64'(e.fim));
            check("vitoria", 64'(vitoria), 64'(e.vit));
            $display("shot: resultado=%b tentativas=%0d acertos=%0d fim=%b vitoria=%b",
                     resultado, tentativas, acertos, fim, vitoria);
         end
      end
   end

   task automatic model_clear();
      m_tiro = '0; m_acerto = '0; m_tent = 0; m_acer = 0;
      m_res = 2'b00; m_fim = 1'b0; m_vit = 1'b0;
   endtask

   task automatic check_state(input string tag);
      check({tag, "_tiro"}, 64'({tiro4, tiro3, tiro2, tiro1, tiro0}), 64'(m_tiro));
      check({tag, "_acerto"}, 64'({acerto4, acerto3, acerto2, acerto1, acerto0}), 64'(m_acerto));
      check({tag, "_tentativas"}, 64'(tentativas), 64'(m_tent));
      check({tag, "_acertos"}, 64'(acertos), 64'(m_acer));
      check({tag, "_resultado"}, 64'(resultado), 64'(m_res));
      check({tag, "_fim"}, 64'(fim), 64'(m_fim));
      check({tag, "_vitoria"}, 64'(vitoria), 64'(m_vit));
      $display("state %s: tentativas=%0d acertos=%0d fim=%b vitoria=%b",
               tag, tentativas, acertos, fim, vitoria);
   endtask

   task automatic model_shot(input int l, input int c, output bit pushed);
      exp_t e;
      int   idx;
      pushed = 1'b0;
      if (m_fim) return;
      if (l > 6 || c > 4) begin
         m_res = 2'b11;
      end else begin
         idx = c * 7 + l;
         if (m_tiro[idx]) begin
            m_res = 2'b11;
         end else begin
            m_tiro[idx] = 1'b1;
            m_tent++;
            if (m_map[idx]) begin
               m_acerto[idx] = 1'b1;
               m_acer++;
               m_res = 2'b10;
            end else begin
               m_res = 2'b01;
            end
         end
      end
      if (m_acer == m_total) begin
         m_fim = 1'b1; m_vit = 1'b1;
      end else if (m_tent == MAXT) begin
         m_fim = 1'b1; m_vit = 1'b0;
      end
      e.res = m_res; e.tiro = m_tiro; e.acerto = m_acerto;
      e.tent = m_tent; e.acer = m_acer; e.fim = m_fim; e.vit = m_vit;
      sb.push_back(e);
      pushed = 1'b1;
   endtask

   task automatic wait_sb(input string tag);
      for (int i = 0; i < 8; i++) begin
         @(negedge clock); #1;
         if (sb.size() == 0) break;
      end
      if (sb.size() != 0) begin
         check({tag, "_timeout"}, 64'(sb.size()), 64'd0);
         sb.delete();
      end
   endtask

   task automatic shoot(input int l, input int c);
      bit pushed;
      model_shot(l, c, pushed);
      @(negedge clock);
      linha = 3'(l); coluna = 3'(c); confirmar = 1'b1;
      @(negedge clock);
      confirmar = 1'b0;
      if (pushed) begin
         wait_sb("shot");
      end else begin
         repeat (6) @(negedge clock);
         check_state("ignored_press");
      end
   endtask

   task automatic start_game(input logic [6:0] a0, input logic [6:0] a1, input logic [6:0] a2,
                             input logic [6:0] a3, input logic [6:0] a4);
      @(negedge clock);
      mapa0 = a0; mapa1 = a1; mapa2 = a2; mapa3 = a3; mapa4 = a4;
      enable = 1'b1;
      m_map = {a4, a3, a2, a1, a0};
      m_total = $countones(m_map);
      model_clear();
      if (m_total == 0) begin
         m_fim = 1'b1; m_vit = 1'b0;
      end
      @(negedge clock);
      check_state("start");
   endtask

   task automatic end_game();
      @(negedge clock);
      enable = 1'b0;
      model_clear();
      @(negedge clock);
      check_state("leave");
   endtask

   initial begin
      repeat (20000) @(posedge clock);
      $display("FAIL watchdog: simulation did not finish, cycle %0d, limit 20000", cyc);
      $fatal(1);
   end

   initial begin
      int rise_cyc, n0;
      reset_n = 1'b0; enable = 1'b0; confirmar = 1'b0;
      linha = '0; coluna = '0;
      mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
      model_clear();
      m_map = '0; m_total = 0;

      // 1. Reset and arm
      @(negedge clock); confirmar = 1'b1;
      @(negedge clock); confirmar = 1'b0; reset_n = 1'b1;
      @(negedge clock); confirmar = 1'b1;
      @(negedge clock); confirmar = 1'b0;
      repeat (3) @(negedge clock);
      check_state("reset");
      start_game(7'b0000011, 7'b0, 7'b0, 7'b0, 7'b0);
      repeat (3) @(negedge clock);
      check_state("armed");
      end_game();

      // 2. Hit, miss, repeat
      start_game(7'b0000011, 7'b0, 7'b0000100, 7'b0, 7'b0);
      shoot(0, 0);
      shoot(1, 1);
      shoot(0, 0);

      // 3. Invalid coordinate and held button
      shoot(7, 0);
      shoot(0, 5);
      begin
         bit pushed;
         model_shot(3, 3, pushed);
         @(negedge clock);
         linha = 3'd3; coluna = 3'd3; confirmar = 1'b1;
         rise_cyc = cyc;
         n0 = pulse_cnt;
         repeat (50) @(negedge clock);
         confirmar = 1'b0;
         check("held_pulses", 64'(pulse_cnt - n0), 64'd1);
         check("held_latency", 64'(pulse_cyc - rise_cyc), 64'd2);
         check("held_sb_empty", 64'(sb.size()), 64'd0);
         sb.delete();
      end
      end_game();

      // 4. Victory, then presses are ignored
      start_game(7'b0000011, 7'b0, 7'b0000100, 7'b0, 7'b0);
      shoot(0, 0);
      shoot(1, 0);
      shoot(2, 2);
      shoot(3, 3);
      end_game();

      // 5. Defeat by attempt limit, then a last-shot victory
      start_game(7'b0000011, 7'b0, 7'b0000100, 7'b0, 7'b0);
      shoot(6, 4);
      shoot(5, 4);
      shoot(4, 4);
      shoot(3, 4);
      shoot(0, 0);
      end_game();
      start_game(7'b0, 7'b0, 7'b0, 7'b0001000, 7'b0);
      shoot(0, 0);
      shoot(1, 1);
      shoot(2, 2);
      shoot(3, 3);
      end_game();

      // 6. Abort during VALIDA, then an empty map
      start_game(7'b0000011, 7'b0, 7'b0000100, 7'b0, 7'b0);
      shoot(0, 0);
      @(negedge clock);
      linha = 3'd1; coluna = 3'd0; confirmar = 1'b1;
      @(negedge clock);
      enable = 1'b0; confirmar = 1'b0;
      model_clear();
      @(negedge clock);
      check_state("abort");
      repeat (3) @(negedge clock);
      check_state("abort_hold");
      start_game(7'b0, 7'b0, 7'b0, 7'b0, 7'b0);
      shoot(0, 0);

      repeat (3) @(negedge clock);
      check("sb_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
